wash_sequencer: RTL and testbench

Parametrised successor to the washing-machine controller FSM. It runs a full wash programme: fill, heat, wash, then N rinse loops, then spin. Its phase timer is internal, and a pause freezes and later restores that timer. Faults latch with a code and hold until resumed. It sits between the user-panel/config logic and the actuator drivers (valve, heater, pump, drum motor).

---
 rtl/wash_pkg.sv | 34 +++
 rtl/wash_phase_timer.sv | 49 ++++
 rtl/wash_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// wash_pkg: state/phase encoding and error codes shared by the
// sequencer, the panel logic and the display logic.
package wash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FILL        = 4'd1,
        ST_HEAT        = 4'd2,
        ST_WASH        = 4'd3,
        ST_DRAIN       = 4'd4,
        ST_RINSE_FILL  = 4'd5,
        ST_RINSE       = 4'd6,
        ST_SPIN        = 4'd7,
        ST_DONE        = 4'd8,
        ST_PAUSE       = 4'd9,
        ST_ABORT_DRAIN = 4'd10
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_VIB   = 2'd1;
    localparam logic [1:0] ERR_FILL  = 2'd2;
    localparam logic [1:0] ERR_DRAIN = 2'd3;

    function automatic logic is_timed(state_e s);
        return s inside {ST_WASH, ST_RINSE, ST_SPIN};
    endfunction

    // Programme phases that can be paused or faulted.
    function automatic logic is_run(state_e s);
        return s inside {ST_FILL, ST_HEAT, ST_WASH, ST_DRAIN,
                         ST_RINSE_FILL, ST_RINSE, ST_SPIN};
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: loadable down-counter with hold and a single
// save/restore slot used to freeze a phase across a pause.
module wash_phase_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               tick_i,
    input  logic               hold_i,
    input  logic               save_i,
    input  logic               restore_i,
    output logic [TIMER_W-1:0] count_o,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] saved_q, saved_d;

    always_comb begin
        count_d = count_q;
        saved_d = saved_q;
        if (save_i) begin
            saved_d = count_q;
        end
        if (restore_i) begin
            count_d = saved_q;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && !hold_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            saved_q <= '0;
        end else begin
            count_q <= count_d;
            saved_q <= saved_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: full wash programme controller with pause/resume,
// latched fault codes and an abort drain path.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TIMER_W    = 16,
    parameter int LEVEL_W    = 10,
    parameter int TEMP_W     = 7,
    parameter int SPEED_W    = 11,
    parameter int MAX_RINSES = 3,
    localparam int RC_W      = $clog2(MAX_RINSES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               resume,
    input  logic               door_closed,
    input  logic               cfg_valid,
    input  logic [TIMER_W-1:0] cfg_wash_ticks,
    input  logic [TIMER_W-1:0] cfg_rinse_ticks,
    input  logic [TIMER_W-1:0] cfg_spin_ticks,
    input  logic [RC_W-1:0]    cfg_rinses,
    input  logic [TEMP_W-1:0]  cfg_temp,
    input  logic [LEVEL_W-1:0] cfg_level,
    input  logic [SPEED_W-1:0] cfg_speed,
    input  logic [LEVEL_W-1:0] level,
    input  logic [TEMP_W-1:0]  temp,
    input  logic               vibration,
    input  logic               flow_fault,
    output logic               door_lock,
    output logic               water_valve,
    output logic               heater,
    output logic               drain_pump,
    output logic [SPEED_W-1:0] motor_speed,
    output logic [3:0]         phase,
    output logic [RC_W-1:0]    rinse_left,
    output logic [TIMER_W-1:0] time_left,
    output logic               busy,
    output logic               done_pulse,
    output logic [1:0]         err_code
);

    localparam logic [RC_W-1:0] RMAX = RC_W'(MAX_RINSES);

    state_e             state_q, state_d;
    state_e             saved_q, saved_d;
    logic [1:0]         err_q, err_d;
    logic [RC_W-1:0]    rinse_q, rinse_d;
    logic               pause_q, resume_q;
    logic [TIMER_W-1:0] wash_q, rinse_t_q, spin_q;
    logic [TEMP_W-1:0]  temp_q;
    logic [LEVEL_W-1:0] level_q;
    logic [SPEED_W-1:0] speed_q;

    logic               latch_cfg;
    logic               t_load, t_hold, t_save, t_restore, t_zero;
    logic [TIMER_W-1:0] t_val;
    logic               pause_edge, resume_edge;
    logic [1:0]         fault_code;
    logic               fault;

    assign pause_edge  = pause & ~pause_q;
    assign resume_edge = resume & ~resume_q;

    always_comb begin
        fault_code = ERR_NONE;
        if (vibration) begin
            fault_code = ERR_VIB;
        end else if (flow_fault) begin
            if (state_q inside {ST_FILL, ST_RINSE_FILL, ST_HEAT}) begin
                fault_code = ERR_FILL;
            end else if (state_q == ST_DRAIN) begin
                fault_code = ERR_DRAIN;
            end
        end
    end

    assign fault = is_run(state_q) && (fault_code != ERR_NONE);

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        err_d     = err_q;
        rinse_d   = rinse_q;
        latch_cfg = 1'b0;
        t_load    = 1'b0;
        t_val     = '0;
        t_hold    = !is_timed(state_q);
        t_save    = 1'b0;
        t_restore = 1'b0;
        if (stop && !(state_q inside {ST_IDLE, ST_DONE})) begin
            state_d = ST_ABORT_DRAIN;
            t_hold  = 1'b1;
        end else if (fault || (pause_edge && is_run(state_q))) begin
            // Freeze the count as it stood before this cycle's tick.
            if (fault) err_d = fault_code;
            saved_d = state_q;
            t_save  = 1'b1;
            t_hold  = 1'b1;
            state_d = ST_PAUSE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && cfg_valid && door_closed) begin
                        state_d   = ST_FILL;
                        latch_cfg = 1'b1;
                        rinse_d   = (cfg_rinses > RMAX) ? RMAX : cfg_rinses;
                    end
                end
                ST_FILL: if (level >= level_q) state_d = ST_HEAT;
                ST_HEAT: begin
                    if (temp >= temp_q) begin
                        state_d = ST_WASH;
                        t_load  = 1'b1;
                        t_val   = wash_q;
                    end
                end
                ST_WASH: if (t_zero) state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (level == '0) begin
                        if (rinse_q != '0) begin
                            state_d = ST_RINSE_FILL;
                        end else begin
                            state_d = ST_SPIN;
                            t_load  = 1'b1;
                            t_val   = spin_q;
                        end
                    end
                end
                ST_RINSE_FILL: begin
                    if (level >= level_q) begin
                        state_d = ST_RINSE;
                        t_load  = 1'b1;
                        t_val   = rinse_t_q;
                    end
                end
                ST_RINSE: begin
                    if (t_zero) begin
                        state_d = ST_DRAIN;
                        rinse_d = rinse_q - 1'b1;
                    end
                end
                ST_SPIN: if (t_zero) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                ST_PAUSE: begin
                    if (resume_edge && !vibration && !flow_fault) begin
                        state_d   = saved_q;
                        t_restore = 1'b1;
                        err_d     = ERR_NONE;
                    end
                end
                ST_ABORT_DRAIN: if (level == '0) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            saved_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            rinse_q  <= '0;
            pause_q  <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            err_q    <= err_d;
            rinse_q  <= rinse_d;
            pause_q  <= pause;
            resume_q <= resume;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wash_q    <= '0;
            rinse_t_q <= '0;
            spin_q    <= '0;
            temp_q    <= '0;
            level_q   <= '0;
            speed_q   <= '0;
        end else if (latch_cfg) begin
            wash_q    <= cfg_wash_ticks;
            rinse_t_q <= cfg_rinse_ticks;
            spin_q    <= cfg_spin_ticks;
            temp_q    <= cfg_temp;
            level_q   <= cfg_level;
            speed_q   <= cfg_speed;
        end
    end

    wash_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .tick_i     (tick),
        .hold_i     (t_hold),
        .save_i     (t_save),
        .restore_i  (t_restore),
        .count_o    (time_left),
        .zero_o     (t_zero)
    );

    always_comb begin
        door_lock   = !(state_q inside {ST_IDLE, ST_DONE});
        busy        = (state_q != ST_IDLE);
        water_valve = state_q inside {ST_FILL, ST_RINSE_FILL};
        heater      = (state_q == ST_HEAT);
        drain_pump  = state_q inside {ST_DRAIN, ST_ABORT_DRAIN};
        done_pulse  = (state_q == ST_DONE);
        motor_speed = '0;
        if (state_q inside {ST_WASH, ST_RINSE}) motor_speed = speed_q;
        if (state_q == ST_SPIN) motor_speed = '1;
    end

    assign phase      = state_q;
    assign rinse_left = rinse_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed programme runs covering nominal flow,
// pause/restore, faults, abort, rinse clamp and async reset.
module tb_wash_sequencer;
    import wash_pkg::*;

    localparam int TIMER_W    = 16;
    localparam int LEVEL_W    = 10;
    localparam int TEMP_W     = 7;
    localparam int SPEED_W    = 11;
    localparam int MAX_RINSES = 3;
    localparam int RC_W       = $clog2(MAX_RINSES + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               tick, start, stop, pause, resume;
    logic               door_closed, cfg_valid;
    logic [TIMER_W-1:0] cfg_wash_ticks, cfg_rinse_ticks, cfg_spin_ticks;
    logic [RC_W-1:0]    cfg_rinses;
    logic [TEMP_W-1:0]  cfg_temp, temp;
    logic [LEVEL_W-1:0] cfg_level, level;
    logic [SPEED_W-1:0] cfg_speed;
    logic               vibration, flow_fault;
    logic               door_lock, water_valve, heater, drain_pump;
    logic [SPEED_W-1:0] motor_speed;
    logic [3:0]         phase;
    logic [RC_W-1:0]    rinse_left;
    logic [TIMER_W-1:0] time_left;
    logic               busy, done_pulse;
    logic [1:0]         err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wash_sequencer #(
        .TIMER_W(TIMER_W), .LEVEL_W(LEVEL_W), .TEMP_W(TEMP_W),
        .SPEED_W(SPEED_W), .MAX_RINSES(MAX_RINSES)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .stop(stop), .pause(pause), .resume(resume),
        .door_closed(door_closed), .cfg_valid(cfg_valid),
        .cfg_wash_ticks(cfg_wash_ticks), .cfg_rinse_ticks(cfg_rinse_ticks),
        .cfg_spin_ticks(cfg_spin_ticks), .cfg_rinses(cfg_rinses),
        .cfg_temp(cfg_temp), .cfg_level(cfg_level), .cfg_speed(cfg_speed),
        .level(level), .temp(temp), .vibration(vibration),
        .flow_fault(flow_fault), .door_lock(door_lock),
        .water_valve(water_valve), .heater(heater),
        .drain_pump(drain_pump), .motor_speed(motor_speed),
        .phase(phase), .rinse_left(rinse_left), .time_left(time_left),
        .busy(busy), .done_pulse(done_pulse), .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int r, input int s,
                           input logic [RC_W-1:0] n);
        cfg_wash_ticks  = TIMER_W'(w);
        cfg_rinse_ticks = TIMER_W'(r);
        cfg_spin_ticks  = TIMER_W'(s);
        cfg_rinses      = n;
    endtask

    int  rinse_visits, spin_cycles, cyc;
    logic seen_done;
    logic [3:0] prev_phase;

    initial begin
        reset = 1'b1;
        {tick, start, stop, pause, resume} = '0;
        {door_closed, cfg_valid, vibration, flow_fault} = '0;
        set_cfg(0, 0, 0, '0);
        cfg_temp  = 7'd40;
        cfg_level = 10'd100;
        cfg_speed = 11'd500;
        level     = '0;
        temp      = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_phase", 32'(phase), 32'(ST_IDLE));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lock", 32'(door_lock), 0);
        chk("rst_motor", 32'(motor_speed), 0);
        chk("rst_time", 32'(time_left), 0);
        chk("rst_rinse", 32'(rinse_left), 0);
        chk("rst_err", 32'(err_code), 0);
        @(negedge clk) reset = 1'b1;
        step();

        // Nominal programme: 2 rinses, wash 4, rinse 2, spin 3.
        set_cfg(4, 2, 3, 2'd2);
        {door_closed, cfg_valid, tick, start} = 4'b1111;
        level = 10'd100;
        temp  = 7'd50;
        step();
        chk("nom_fill", 32'(phase), 32'(ST_FILL));
        chk("nom_valve", 32'(water_valve), 1);
        chk("nom_rl", 32'(rinse_left), 2);
        start = 1'b0;
        step();
        chk("nom_heat", 32'(phase), 32'(ST_HEAT));
        chk("nom_heater", 32'(heater), 1);
        step();
        chk("nom_wash", 32'(phase), 32'(ST_WASH));
        chk("nom_wash_tl", 32'(time_left), 4);
        chk("nom_wash_mot", 32'(motor_speed), 500);
        repeat (4) step();
        chk("nom_wash_end", 32'(phase), 32'(ST_WASH));
        chk("nom_wash_tl0", 32'(time_left), 0);
        step();
        chk("nom_drain", 32'(phase), 32'(ST_DRAIN));
        chk("nom_pump", 32'(drain_pump), 1);
        level = '0;
        for (int r = 2; r >= 1; r--) begin
            step();
            chk("nom_rfill", 32'(phase), 32'(ST_RINSE_FILL));
            level = 10'd100;
            step();
            chk("nom_rinse", 32'(phase), 32'(ST_RINSE));
            chk("nom_rinse_tl", 32'(time_left), 2);
            repeat (2) step();
            chk("nom_rinse_end", 32'(phase), 32'(ST_RINSE));
            step();
            chk("nom_drain_r", 32'(phase), 32'(ST_DRAIN));
            chk("nom_rl_dec", 32'(rinse_left), 32'(r - 1));
            level = '0;
        end
        step();
        chk("nom_spin", 32'(phase), 32'(ST_SPIN));
        chk("nom_spin_mot", 32'(motor_speed), 2047);
        chk("nom_spin_tl", 32'(time_left), 3);
        repeat (3) step();
        chk("nom_spin_end", 32'(phase), 32'(ST_SPIN));
        step();
        chk("nom_done", 32'(phase), 32'(ST_DONE));
        chk("nom_done_p", 32'(done_pulse), 1);
        step();
        chk("nom_idle", 32'(phase), 32'(ST_IDLE));
        chk("nom_done_p0", 32'(done_pulse), 0);
        chk("nom_busy0", 32'(busy), 0);

        // Pause during WASH at time_left=3, ticking while paused.
        set_cfg(6, 2, 0, 2'd1);
        level = 10'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("p_wash", 32'(phase), 32'(ST_WASH));
        repeat (3) step();
        chk("p_tl3", 32'(time_left), 3);
        pause = 1'b1;
        step();
        chk("p_pause", 32'(phase), 32'(ST_PAUSE));
        chk("p_tl_frz", 32'(time_left), 3);
        chk("p_lock", 32'(door_lock), 1);
        chk("p_motor0", 32'(motor_speed), 0);
        repeat (10) step();
        chk("p_hold", 32'(phase), 32'(ST_PAUSE));
        chk("p_hold_tl", 32'(time_left), 3);
        pause  = 1'b0;
        resume = 1'b1;
        step();
        chk("p_resumed", 32'(phase), 32'(ST_WASH));
        chk("p_res_tl", 32'(time_left), 3);
        resume = 1'b0;
        repeat (3) step();
        chk("p_wash_end", 32'(phase), 32'(ST_WASH));
        chk("p_wash_tl0", 32'(time_left), 0);
        step();
        chk("p_drain", 32'(phase), 32'(ST_DRAIN));

        // Vibration in RINSE, refused resume, then clean resume.
        level = '0;
        step();
        level = 10'd100;
        step();
        chk("v_rinse", 32'(phase), 32'(ST_RINSE));
        vibration = 1'b1;
        step();
        chk("v_pause", 32'(phase), 32'(ST_PAUSE));
        chk("v_err", 32'(err_code), 1);
        chk("v_tl", 32'(time_left), 2);
        resume = 1'b1;
        step();
        chk("v_refused", 32'(phase), 32'(ST_PAUSE));
        chk("v_err_hold", 32'(err_code), 1);
        resume    = 1'b0;
        vibration = 1'b0;
        step();
        resume = 1'b1;
        step();
        chk("v_back", 32'(phase), 32'(ST_RINSE));
        chk("v_err_clr", 32'(err_code), 0);
        chk("v_tl_rest", 32'(time_left), 2);
        resume = 1'b0;
        repeat (3) step();
        chk("f_drain", 32'(phase), 32'(ST_DRAIN));
        chk("f_rl0", 32'(rinse_left), 0);

        // Drain flow fault, then stop from PAUSE.
        flow_fault = 1'b1;
        step();
        chk("f_pause", 32'(phase), 32'(ST_PAUSE));
        chk("f_err3", 32'(err_code), 3);
        flow_fault = 1'b0;
        stop       = 1'b1;
        step();
        chk("a_abort", 32'(phase), 32'(ST_ABORT_DRAIN));
        chk("a_pump", 32'(drain_pump), 1);
        chk("a_valve", 32'(water_valve), 0);
        stop  = 1'b0;
        level = '0;
        step();
        chk("a_idle", 32'(phase), 32'(ST_IDLE));
        chk("a_unlock", 32'(door_lock), 0);

        // Rinse count at its ceiling, zero-length spin.
        set_cfg(1, 0, 0, '1);
        level = 10'd100;
        start = 1'b1;
        rinse_visits = 0;
        spin_cycles  = 0;
        seen_done    = 1'b0;
        prev_phase   = 4'(ST_IDLE);
        cyc          = 0;
        while (!seen_done && cyc < 200) begin
            step();
            start = 1'b0;
            cyc++;
            if (phase == 4'(ST_RINSE) && prev_phase != 4'(ST_RINSE))
                rinse_visits++;
            if (phase == 4'(ST_SPIN)) spin_cycles++;
            if (phase == 4'(ST_DONE)) seen_done = 1'b1;
            level = (phase == 4'(ST_DRAIN)) ? 10'd0 : 10'd100;
            prev_phase = phase;
        end
        chk("c_done_seen", 32'(seen_done), 1);
        chk("c_rinses", 32'(rinse_visits), 3);
        chk("c_spin1", 32'(spin_cycles), 1);
        step();

        // Asynchronous reset while heating.
        temp  = '0;
        level = 10'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("r_heat", 32'(phase), 32'(ST_HEAT));
        chk("r_heater", 32'(heater), 1);
        #2 reset = 1'b0;
        #1;
        chk("r_phase0", 32'(phase), 32'(ST_IDLE));
        chk("r_heater0", 32'(heater), 0);
        chk("r_lock0", 32'(door_lock), 0);
        chk("r_busy0", 32'(busy), 0);
        chk("r_rl0", 32'(rinse_left), 0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("r_idle", 32'(phase), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
